// File: rtl/code_lock_ctrl.sv
// Keypad combination-lock controller: PIN compare, timed open, two-step PIN change, lockout.
// Optional CODE_LOCK_ENTRY_TIMEOUT_EN adds an inactivity timeout on partial entries.
module code_lock_ctrl #(
    parameter int DIGIT_W     = 4,
    parameter int PIN_LEN     = 4,
    parameter int MAX_FAIL    = 3,
    parameter int OPEN_CYC    = 500,
    parameter int LOCKOUT_CYC = 1000,
    parameter int TIMEOUT_CYC = 2000,
    parameter logic [PIN_LEN*DIGIT_W-1:0] DEFAULT_PIN = {4'd1, 4'd2, 4'd3, 4'd4},
    parameter logic [DIGIT_W-1:0] KEY_ENTER = 4'b1011,
    parameter logic [DIGIT_W-1:0] KEY_STAR  = 4'b1010
) (
    input  logic                            clk,
    input  logic                            reset_1,
    input  logic [DIGIT_W-1:0]              Code_1,
    input  logic                            Valid_1,
    output logic                            OPEN,
    output logic                            LOCK,
    output logic                            SAVE_LIGHT,
    output logic                            ALARM,
    output logic                            ERR,
    output logic                            SAVE_DONE,
    output logic [$clog2(MAX_FAIL+1)-1:0]   fail_count,
    output logic [2:0]                      state_dbg
);
    localparam int PW   = PIN_LEN * DIGIT_W;
    localparam int CW   = $clog2(PIN_LEN + 1);
    localparam int FW   = $clog2(MAX_FAIL + 1);
    localparam int TMAX = (OPEN_CYC > LOCKOUT_CYC) ? OPEN_CYC : LOCKOUT_CYC;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam logic [TW-1:0] OPEN_LD = TW'(OPEN_CYC - 1);
    localparam logic [TW-1:0] LOCK_LD = TW'(LOCKOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_LOCKED  = 3'd0,
        S_OPEN    = 3'd1,
        S_SAVE1   = 3'd2,
        S_SAVE2   = 3'd3,
        S_LOCKOUT = 3'd4
    } state_t;

    state_t          state_q, state_n;
    logic [PW-1:0]   buf_q, buf_n, pin_q, pin_n, stash_q, stash_n;
    logic [CW-1:0]   cnt_q, cnt_n;
    logic            ovf_q, ovf_n;
    logic [TW-1:0]   tmr_q, tmr_n;
    logic [FW-1:0]   fail_n;
    logic            err_n, done_n, clr;
    logic            open_n, lock_n, save_n, alarm_n;
    logic            is_digit, is_enter, is_star, full, match_pin, match_stash, tmo;

`ifdef CODE_LOCK_ENTRY_TIMEOUT_EN
    localparam int IW = $clog2(TIMEOUT_CYC + 1);
    logic [IW-1:0] idle_q, idle_n;
    assign tmo = !Valid_1 && (idle_q == IW'(TIMEOUT_CYC - 1));
`else
    assign tmo = 1'b0;
`endif

    assign is_digit    = Valid_1 && (Code_1 <= DIGIT_W'(9));
    assign is_enter    = Valid_1 && (Code_1 == KEY_ENTER);
    assign is_star     = Valid_1 && (Code_1 == KEY_STAR);
    assign full        = (cnt_q == CW'(PIN_LEN)) && !ovf_q;
    assign match_pin   = full && (buf_q == pin_q);
    assign match_stash = full && (buf_q == stash_q);

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset_1) begin
            state_q    <= S_LOCKED;
            buf_q      <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            pin_q      <= DEFAULT_PIN;
            stash_q    <= '0;
            tmr_q      <= '0;
            fail_count <= '0;
            OPEN       <= 1'b0;
            LOCK       <= 1'b1;
            SAVE_LIGHT <= 1'b0;
            ALARM      <= 1'b0;
            ERR        <= 1'b0;
            SAVE_DONE  <= 1'b0;
        end else begin
            state_q    <= state_n;
            buf_q      <= buf_n;
            cnt_q      <= cnt_n;
            ovf_q      <= ovf_n;
            pin_q      <= pin_n;
            stash_q    <= stash_n;
            tmr_q      <= tmr_n;
            fail_count <= fail_n;
            OPEN       <= open_n;
            LOCK       <= lock_n;
            SAVE_LIGHT <= save_n;
            ALARM      <= alarm_n;
            ERR        <= err_n;
            SAVE_DONE  <= done_n;
        end
    end

`ifdef CODE_LOCK_ENTRY_TIMEOUT_EN
    assign idle_n = (Valid_1 || tmo || (state_n != state_q)) ? '0 : idle_q + 1'b1;
    always_ff @(posedge clk) begin
        if (reset_1) idle_q <= '0;
        else         idle_q <= idle_n;
    end
`endif

    assign state_dbg = state_q;

    // Next-state and datapath update
    always_comb begin
        state_n = state_q;
        buf_n   = buf_q;
        cnt_n   = cnt_q;
        ovf_n   = ovf_q;
        pin_n   = pin_q;
        stash_n = stash_q;
        tmr_n   = tmr_q;
        fail_n  = fail_count;
        err_n   = 1'b0;
        done_n  = 1'b0;
        clr     = 1'b0;

        if (is_digit && (state_q == S_LOCKED || state_q == S_SAVE1 || state_q == S_SAVE2)) begin
            if (cnt_q == CW'(PIN_LEN)) begin
                ovf_n = 1'b1;
            end else begin
                buf_n[(PIN_LEN-1-int'(cnt_q))*DIGIT_W +: DIGIT_W] = Code_1;
                cnt_n = cnt_q + 1'b1;
            end
        end

        case (state_q)
            S_LOCKED: begin
                if (is_star) begin
                    clr = 1'b1;
                end else if (is_enter) begin
                    if (match_pin) begin
                        state_n = S_OPEN;
                        fail_n  = '0;
                    end else begin
                        err_n  = 1'b1;
                        clr    = 1'b1;
                        fail_n = (fail_count == FW'(MAX_FAIL)) ? fail_count : fail_count + 1'b1;
                        if (fail_n == FW'(MAX_FAIL)) state_n = S_LOCKOUT;
                    end
                end else if (tmo && cnt_q != '0) begin
                    clr = 1'b1;
                end
            end
            S_OPEN: begin
                // Enter/Star win over expiry on the same cycle
                if (is_enter)           tmr_n   = OPEN_LD;
                else if (is_star)       state_n = S_SAVE1;
                else if (tmr_q == '0)   state_n = S_LOCKED;
                else                    tmr_n   = tmr_q - 1'b1;
            end
            S_SAVE1: begin
                if (is_enter) begin
                    if (full) begin
                        stash_n = buf_q;
                        state_n = S_SAVE2;
                    end else begin
                        err_n   = 1'b1;
                        state_n = S_LOCKED;
                    end
                end else if (is_star) begin
                    state_n = S_LOCKED;
                end else if (tmo) begin
                    err_n   = 1'b1;
                    state_n = S_LOCKED;
                end
            end
            S_SAVE2: begin
                if (is_enter) begin
                    if (match_stash) begin
                        pin_n  = stash_q;
                        done_n = 1'b1;
                    end else begin
                        err_n  = 1'b1;
                    end
                    state_n = S_LOCKED;
                end else if (is_star) begin
                    state_n = S_LOCKED;
                end else if (tmo) begin
                    err_n   = 1'b1;
                    state_n = S_LOCKED;
                end
            end
            S_LOCKOUT: begin
                if (tmr_q == '0) begin
                    state_n = S_LOCKED;
                    fail_n  = '0;
                end else begin
                    tmr_n = tmr_q - 1'b1;
                end
            end
            default: state_n = S_LOCKED;
        endcase

        if (clr || state_n != state_q) begin
            buf_n = '0;
            cnt_n = '0;
            ovf_n = 1'b0;
        end
        if (state_n == S_OPEN && state_q != S_OPEN)       tmr_n = OPEN_LD;
        if (state_n == S_LOCKOUT && state_q != S_LOCKOUT) tmr_n = LOCK_LD;
    end

    // Output decode from the next state, registered above
    always_comb begin
        open_n  = (state_n == S_OPEN);
        lock_n  = (state_n != S_OPEN);
        save_n  = (state_n == S_SAVE1) || (state_n == S_SAVE2);
        alarm_n = (state_n == S_LOCKOUT);
    end
endmodule
